// File: rtl/alu4_pkg.sv
// alu4_pkg: shared definitions for the 4-bit registered ALU.
//   - arith_op_e : arithmetic opcodes, encoded on {select[1:0], carry_in}
//   - LOGIC_*    : logic-unit codes on the full 3-bit select (select[2]=1)
//   - arith_code : packs select[1:0] and carry_in into an arith_op_e
package alu4_pkg;

  localparam int unsigned WIDTH = 4;

  typedef enum logic [2:0] {
    OP_TRANSFER      = 3'd0,
    OP_INCREMENT     = 3'd1,
    OP_ADD           = 3'd2,
    OP_ADD_INCREMENT = 3'd3,
    OP_ADD_INVERT    = 3'd4,
    OP_SUBTRACT      = 3'd5,
    OP_DECREMENT     = 3'd6,
    OP_ADD_CARRY     = 3'd7
  } arith_op_e;

  localparam logic [2:0] LOGIC_AND = 3'd4;
  localparam logic [2:0] LOGIC_OR  = 3'd5;
  localparam logic [2:0] LOGIC_XOR = 3'd6;
  localparam logic [2:0] LOGIC_NOT = 3'd7;

  function automatic arith_op_e arith_code(input logic [1:0] sel_lo,
                                           input logic carry_in);
    return arith_op_e'({sel_lo, carry_in});
  endfunction

endpackage

// File: rtl/alu4_if.sv
// alu4_if: operand/result bundle of the 4-bit ALU.
//   a, b      : operands (master -> slave)
//   carry_in  : arithmetic sub-op select (master -> slave)
//   select    : [2]=0 arithmetic, [2]=1 logic; [1:0] picks the op
//   out       : registered 4-bit result (slave -> master)
//   carry_out : registered carry/borrow flag (slave -> master)
// Handshake: there is none. The slave samples a/b/carry_in/select on every
// rising clock edge and presents the matching out/carry_out right after that
// same edge; a new operation may be issued every cycle.
interface alu4_if;
  import alu4_pkg::*;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic [2:0]       select;
  logic [WIDTH-1:0] out;
  logic             carry_out;

  modport master (
    output a, b, carry_in, select,
    input  out, carry_out
  );

  modport slave (
    input  a, b, carry_in, select,
    output out, carry_out
  );

endinterface

// File: rtl/alu4_arith.sv
// alu4_arith: combinational arithmetic unit.
//   Ports: a, b (4-bit operands), sel_lo (select[1:0]), carry_in,
//          r (5-bit result; r[4] becomes carry_out, r[3:0] becomes out).
// Every op is evaluated in 5-bit modular arithmetic. For the subtracting
// ops the zero-extended difference goes negative exactly when a borrow
// occurs, so r[4] is the borrow flag directly (not the adder carry of a+~b).
module alu4_arith
  import alu4_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel_lo,
  input  logic             carry_in,
  output logic [WIDTH:0]   r
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  arith_op_e      op;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};
  assign op    = arith_code(sel_lo, carry_in);

  // b only enters the ops that use it, so an undriven b cannot leak into
  // TRANSFER / INCREMENT / DECREMENT / ADD_CARRY results.
  always_comb begin
    r = '0;
    unique case (op)
      OP_TRANSFER:      r = a_ext;
      OP_INCREMENT:     r = a_ext + 5'd1;
      OP_ADD:           r = a_ext + b_ext;
      OP_ADD_INCREMENT: r = a_ext + b_ext + 5'd1;
      OP_ADD_INVERT:    r = a_ext - b_ext - 5'd1;  // r[4]=1 iff a<=b
      OP_SUBTRACT:      r = a_ext - b_ext;         // r[4]=1 iff a<b
      OP_DECREMENT:     r = a_ext - 5'd1;          // r[4]=1 iff a==0
      OP_ADD_CARRY:     r = a_ext + 5'd2;          // r[4]=1 iff a>=14
      default:          r = '0;
    endcase
  end

endmodule

// File: rtl/alu4.sv
// alu4: 4-bit registered ALU.
//   Ports: clk       - rising-edge clock
//          rst_n     - asynchronous active-low reset (clears out/carry_out)
//          bus       - alu4_if.slave: a, b, carry_in, select in;
//                      out, carry_out registered out
// select[2]=0 routes the 5-bit result of alu4_arith to {carry_out,out};
// select[2]=1 routes the logic unit (AND/OR/XOR/NOT) with carry_out forced
// to 0 and carry_in ignored.
module alu4
  import alu4_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  alu4_if.slave  bus
);

  logic [WIDTH:0]   arith_r;
  logic [WIDTH-1:0] logic_r;

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             carry_d;
  logic             carry_q;

  alu4_arith u_arith (
    .a        (bus.a),
    .b        (bus.b),
    .sel_lo   (bus.select[1:0]),
    .carry_in (bus.carry_in),
    .r        (arith_r)
  );

  // Logic unit; NOT uses only a.
  always_comb begin
    logic_r = '0;
    unique case ({1'b1, bus.select[1:0]})
      LOGIC_AND: logic_r = bus.a & bus.b;
      LOGIC_OR:  logic_r = bus.a | bus.b;
      LOGIC_XOR: logic_r = bus.a ^ bus.b;
      LOGIC_NOT: logic_r = ~bus.a;
      default:   logic_r = '0;
    endcase
  end

  always_comb begin
    out_d   = arith_r[WIDTH-1:0];
    carry_d = arith_r[WIDTH];
    if (bus.select[2]) begin
      out_d   = logic_r;
      carry_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_alu4.sv
// tb_alu4: directed bench for the 4-bit registered ALU, plus a full sweep
// checked against a behavioural model through an expected queue.
module tb_alu4;
  import alu4_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu4_if bus_if ();

  alu4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] sel, input logic ci,
                       input logic [3:0] a, input logic [3:0] b);
    bus_if.select   = sel;
    bus_if.carry_in = ci;
    bus_if.a        = a;
    bus_if.b        = b;
  endtask

  // Drive an arithmetic code 0..7 expressed as {select[1:0],carry_in}.
  task automatic drive_arith(input logic [2:0] code,
                             input logic [3:0] a, input logic [3:0] b);
    drive({1'b0, code[2:1]}, code[0], a, b);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] ref_model(input logic [2:0] sel, input logic ci,
                                           input logic [3:0] a, input logic [3:0] b);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    if (sel[2]) begin
      case (sel[1:0])
        2'd0: r = ia & ib;
        2'd1: r = ia | ib;
        2'd2: r = ia ^ ib;
        default: r = 15 - ia;
      endcase
    end else begin
      case ({sel[1:0], ci})
        3'd0: r = ia;
        3'd1: r = ia + 1;
        3'd2: r = ia + ib;
        3'd3: r = ia + ib + 1;
        3'd4: r = ia - ib - 1;
        3'd5: r = ia - ib;
        3'd6: r = ia - 1;
        default: r = ia + 2;
      endcase
    end
    r = r & 31;
    return r[4:0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    drive(3'd0, 1'b0, 4'd0, 4'd0);
    #2;
    checks++;
    if ({bus_if.carry_out, bus_if.out} !== 5'b0_0000) begin
      errors++;
      $display("FAIL reset_initial: got %b_%b want 0_0000", bus_if.carry_out, bus_if.out);
    end
    step();
    checks++;
    if ({bus_if.carry_out, bus_if.out} !== 5'b0_0000) begin
      errors++;
      $display("FAIL reset_hold_edge: got %b_%b want 0_0000", bus_if.carry_out, bus_if.out);
    end
    rst_n = 1'b1;
    // ADD 15+11 = 26 -> carry_out=1, out=1010
    drive_arith(3'd2, 4'd15, 4'd11);
    step();
    checks++;
    if ({bus_if.carry_out, bus_if.out} !== 5'b1_1010) begin
      errors++;
      $display("FAIL pre_reset_add: got %b_%b want 1_1010", bus_if.carry_out, bus_if.out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.carry_out, bus_if.out} !== 5'b0_0000) begin
      errors++;
      $display("FAIL reset_async: got %b_%b want 0_0000", bus_if.carry_out, bus_if.out);
    end
    step();
    checks++;
    if ({bus_if.carry_out, bus_if.out} !== 5'b0_0000) begin
      errors++;
      $display("FAIL reset_hold_active: got %b_%b want 0_0000", bus_if.carry_out, bus_if.out);
    end
    #2;
    rst_n = 1'b1;
    drive_arith(3'd2, 4'd3, 4'd4);
    step();
    checks++;
    if ({bus_if.carry_out, bus_if.out} !== 5'b0_0111) begin
      errors++;
      $display("FAIL post_reset_add: got %b_%b want 0_0111", bus_if.carry_out, bus_if.out);
    end
  endtask

  // Arithmetic directed vectors: code, a, b, expected {carry_out,out}.
  task automatic test_arith_edges;
    logic [2:0] code [12] = '{3'd2, 3'd3, 3'd1, 3'd5, 3'd5, 3'd4,
                              3'd4, 3'd6, 3'd6, 3'd7, 3'd0, 3'd7};
    logic [3:0] ta   [12] = '{4'd15, 4'd15, 4'd15, 4'd5, 4'd3, 4'd5,
                              4'd6, 4'd0, 4'd1, 4'd14, 4'd9, 4'd13};
    logic [3:0] tb   [12] = '{4'd1, 4'd15, 4'd7, 4'd3, 4'd5, 4'd5,
                              4'd5, 4'd9, 4'd2, 4'd3, 4'd6, 4'd8};
    logic [4:0] texp [12] = '{5'b1_0000, 5'b1_1111, 5'b1_0000, 5'b0_0010,
                              5'b1_1110, 5'b1_1111, 5'b0_0000, 5'b1_1111,
                              5'b0_0000, 5'b1_0000, 5'b0_1001, 5'b0_1111};
    for (int i = 0; i < 12; i++) begin
      drive_arith(code[i], ta[i], tb[i]);
      step();
      checks++;
      if ({bus_if.carry_out, bus_if.out} !== texp[i]) begin
        errors++;
        $display("FAIL arith_vec%0d code=%0d a=%0d b=%0d: got %b_%b want %b",
                 i, code[i], ta[i], tb[i], bus_if.carry_out, bus_if.out, texp[i]);
      end
    end
  endtask

  // a=1100, b=1010 with carry_in 0 and 1: AND/OR/XOR/NOT.
  task automatic test_logic;
    logic [3:0] lexp [4] = '{4'b1000, 4'b1110, 4'b0110, 4'b0011};
    for (int ci = 0; ci < 2; ci++) begin
      for (int k = 0; k < 4; k++) begin
        drive(3'd4 + 3'(k), ci[0], 4'b1100, 4'b1010);
        step();
        checks++;
        if ({bus_if.carry_out, bus_if.out} !== {1'b0, lexp[k]}) begin
          errors++;
          $display("FAIL logic sel=%0d ci=%0d: got %b_%b want 0_%b",
                   4 + k, ci, bus_if.carry_out, bus_if.out, lexp[k]);
        end
      end
    end
  endtask

  // Full sweep, one op per cycle, checked one cycle later from exp_q.
  task automatic test_back_to_back;
    logic [2:0] sel;
    logic       ci;
    logic [4:0] exp;
    for (int c = 0; c < 12; c++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          if (c < 8) begin
            sel = {1'b0, 2'(c >> 1)};
            ci  = c[0];
          end else begin
            sel = 3'(c - 4);
            ci  = 1'($urandom_range(0, 1));
          end
          drive(sel, ci, 4'(ia), 4'(ib));
          exp_q.push_back(ref_model(sel, ci, 4'(ia), 4'(ib)));
          step();
          exp = exp_q.pop_front();
          checks++;
          if ({bus_if.carry_out, bus_if.out} !== exp) begin
            errors++;
            $display("FAIL sweep sel=%0d ci=%0d a=%0d b=%0d: got %b_%b want %b",
                     sel, ci, ia, ib, bus_if.carry_out, bus_if.out, exp);
          end
        end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_arith_edges();
    test_logic();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu4.md
Name: alu4

Overview:
- 4-bit registered ALU with eight arithmetic operations (select[2]=0) and four bitwise logic operations (select[2]=1).
- Operation code is {select, carry_in}.
- Leaf datapath block for small CPU/teaching datapaths.
- Inputs are sampled on the clock; out and carry_out are registered.

Parameters:
- none; width is fixed at 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  4  operand A
- b  input  4  operand B
- carry_in  input  1  arithmetic sub-op select; ignored for logic ops
- select  input  3  [2]=0 arithmetic, [2]=1 logic; [1:0] picks the op
- out  output  4  registered result
- carry_out  output  1  registered carry/borrow flag

Behaviour:
- Reset: rst_n low asynchronously forces out=0 and carry_out=0; both hold while rst_n is low.
- Latency: the result for inputs sampled at rising edge N appears at edge N, i.e. is valid after that edge. It is stable until the next edge (1-cycle registered latency, no handshake, one new op every cycle).
- Arithmetic results are computed as a 5-bit value R, with {carry_out,out}=R[4:0]. Modular (mod 32) wrap applies throughout.
- Arithmetic ops by {select[1:0],carry_in}:
  - 00,0 TRANSFER: R=a; carry_out=0.
  - 00,1 INCREMENT: R=a+1; carry_out=1 only for a=15.
  - 01,0 ADD: R=a+b.
  - 01,1 ADD_INCREMENT: R=a+b+1.
  - 10,0 ADD_INVERT: R=a-b-1 mod 32; carry_out=1 iff a<=b.
  - 10,1 SUBTRACT: R=a-b mod 32; carry_out=1 iff a<b (borrow).
  - 11,0 DECREMENT: R=a-1 mod 32; carry_out=1 iff a=0 (borrow).
  - 11,1 ADD_CARRY: R=a+2; carry_out=1 iff a>=14.
- For the two inverted/subtract ops, carry_out is a borrow flag. It is not the raw adder carry of a+~b.
- Logic ops by select[1:0], with carry_in ignored and carry_out=0:
  - 00 AND: out=a&b.
  - 01 OR: out=a|b.
  - 10 XOR: out=a^b.
  - 11 NOT: out=~a; b is ignored.
- No X propagation from unused inputs: b is don't-care for TRANSFER, INCREMENT, DECREMENT, ADD_CARRY and NOT. The result depends only on the documented operands.
- If rst_n is deasserted between edges, the first result appears at the next rising edge.

Decomposition:
- Package alu4_pkg holds:
  - an opcode enum for the arithmetic codes 0..7 (TRANSFER..ADD_CARRY) on {select[1:0],carry_in};
  - logic constants AND=4, OR=5, XOR=6, NOT=7 on select.
- One combinational sub-module, alu4_arith, maps (a, b, select[1:0], carry_in) to the 5-bit R.
- The top level holds the logic unit, the select[2] mux and the output register.

Test Plan:
- Reset: rst_n=0 mid-stream with out=1010 -> out=0000 and carry_out=0 immediately, without waiting for a clock edge. Release, then apply ADD a=3,b=4 -> out=0111 and carry_out=0 after one edge.
- Add/increment with carry: ADD a=15,b=1 -> out=0000, carry_out=1. ADD_INCREMENT a=15,b=15 -> out=1111, carry_out=1. INCREMENT a=15 -> out=0000, carry_out=1.
- Subtract/borrow: SUBTRACT a=5,b=3 -> 0010, carry_out=0. SUBTRACT a=3,b=5 -> 1110, carry_out=1. ADD_INVERT a=5,b=5 -> 1111, carry_out=1. ADD_INVERT a=6,b=5 -> 0000, carry_out=0.
- Decrement/add_carry edges: DECREMENT a=0 -> 1111, carry_out=1. DECREMENT a=1 -> 0000, carry_out=0. ADD_CARRY a=14 -> 0000, carry_out=1. TRANSFER a=9,b=6 -> 1001, carry_out=0.
- Logic with carry_in=0 and 1: a=1100,b=1010 gives AND 1000, OR 1110, XOR 0110, NOT 0011, with carry_out=0 in every case.
- Exhaustive sweep: a,b over 0..15 with all 8 arithmetic and 4 logic codes, one op per cycle. Compare {carry_out,out} against the reference model delayed by one cycle.
